// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// the eight instruction opcodes and a helper that flags memory opcodes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_FETCH  = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } ctrl_state_t;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_JMP = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    // True for opcodes whose EXEC phase waits on the memory handshake.
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_LDA) || (op == OP_STA);
    endfunction

endpackage

// File: rtl/ctrl_mem_watchdog.sv
// Memory-wait watchdog: counts stalled cycles of the current access and
// flags expiry when the count has reached TIMEOUT while still stalled.
module ctrl_mem_watchdog #(
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    logic [TO_W-1:0] count_reg;

    // Count stalled cycles; a state change starts a fresh access window.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (waiting && (count_reg != TO_W'(TIMEOUT))) begin
            count_reg <= count_reg + TO_W'(1);
        end
    end

    assign expired = waiting && (count_reg == TO_W'(TIMEOUT));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC sequencer with free-run
// and single-step modes, memory wait handshake and a retired-instruction
// counter. Define CTRL_TIMEOUT_EN to add the memory-wait watchdog and the
// FAULT trap; without it memory waits are unbounded and fault is tied low.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             run,
    input  logic [2:0]       op_code,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             rd_mem,
    output logic             wr_mem,
    output logic             ir_on_adr,
    output logic             pc_on_adr,
    output logic             dbus_on_data,
    output logic             data_on_dbus,
    output logic             ld_ir,
    output logic             ld_ac,
    output logic             ld_pc,
    output logic             inc_pc,
    output logic             clr_pc,
    output logic             pass,
    output logic             add,
    output logic             sub,
    output logic             alu_on_dbus,
    output logic             idle,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    ctrl_state_t      state_reg, state_next;
    logic [CNT_W-1:0] retired_reg;
    logic             exec_done;
    logic             wd_expired;

`ifdef CTRL_TIMEOUT_EN
    ctrl_mem_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_next != state_reg),
        .waiting (mem_req && !mem_ready),
        .expired (wd_expired)
    );
    assign fault = (state_reg == ST_FAULT);
`else
    assign wd_expired = 1'b0;
    assign fault      = 1'b0;
    wire unused_cfg = ^{TO_W[0], TIMEOUT[0]};
`endif

    // State register; reset from any state lands in RESET on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    // Retired counter steps on the EXEC completion cycle and wraps freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_reg <= '0;
        end else if (exec_done) begin
            retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    assign retired = retired_reg;

    // Next-state and Moore/Mealy control outputs, all defaulting to 0.
    always_comb begin
        state_next   = state_reg;
        exec_done    = 1'b0;
        mem_req      = 1'b0;
        rd_mem       = 1'b0;
        wr_mem       = 1'b0;
        ir_on_adr    = 1'b0;
        pc_on_adr    = 1'b0;
        dbus_on_data = 1'b0;
        data_on_dbus = 1'b0;
        ld_ir        = 1'b0;
        ld_ac        = 1'b0;
        ld_pc        = 1'b0;
        inc_pc       = 1'b0;
        clr_pc       = 1'b0;
        pass         = 1'b0;
        add          = 1'b0;
        sub          = 1'b0;
        alu_on_dbus  = 1'b0;
        idle         = 1'b0;
        halted       = 1'b0;
        case (state_reg)
            ST_RESET: begin
                clr_pc     = 1'b1;
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                idle = 1'b1;
                if (run || step) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req      = 1'b1;
                pc_on_adr    = 1'b1;
                rd_mem       = 1'b1;
                data_on_dbus = 1'b1;
                ld_ir        = mem_ready;
                inc_pc       = mem_ready;
                if (mem_ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_code)
                    OP_LDA: begin
                        mem_req      = 1'b1;
                        ir_on_adr    = 1'b1;
                        rd_mem       = 1'b1;
                        data_on_dbus = 1'b1;
                        ld_ac        = mem_ready;
                    end
                    OP_STA: begin
                        mem_req      = 1'b1;
                        pass         = 1'b1;
                        ir_on_adr    = 1'b1;
                        alu_on_dbus  = 1'b1;
                        dbus_on_data = 1'b1;
                        wr_mem       = 1'b1;
                    end
                    OP_JMP: ld_pc = 1'b1;
                    OP_ADD: begin
                        add         = 1'b1;
                        alu_on_dbus = 1'b1;
                        ld_ac       = 1'b1;
                    end
                    OP_SUB: begin
                        sub         = 1'b1;
                        alu_on_dbus = 1'b1;
                        ld_ac       = 1'b1;
                    end
                    OP_JZ:  ld_pc = zero;
                    OP_NOP: ;
                    OP_HLT: ;
                endcase
                exec_done = is_mem_op(op_code) ? mem_ready : 1'b1;
                if (exec_done) begin
                    if (op_code == OP_HLT) state_next = ST_HALT;
                    else if (run)          state_next = ST_FETCH;
                    else                   state_next = ST_IDLE;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_FAULT: ;
            default: state_next = ST_RESET;
        endcase
        if (wd_expired) state_next = ST_FAULT;
        if (reset) begin
            state_next = ST_RESET;
            exec_done  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each cycle pushes the expected
// control word and retired count to a scoreboard, then pops and compares
// them against the DUT once outputs have settled.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset, step, run, zero, mem_ready;
    logic [2:0]  op_code;
    logic        mem_req, rd_mem, wr_mem, ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus;
    logic        ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, sub, alu_on_dbus;
    logic        idle, halted, fault;
    logic [15:0] retired;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] ret     = '0;

    localparam logic [18:0] B_MEM_REQ = 19'h40000;
    localparam logic [18:0] B_RD_MEM  = 19'h20000;
    localparam logic [18:0] B_WR_MEM  = 19'h10000;
    localparam logic [18:0] B_IR_ADR  = 19'h08000;
    localparam logic [18:0] B_PC_ADR  = 19'h04000;
    localparam logic [18:0] B_DB_DATA = 19'h02000;
    localparam logic [18:0] B_DATA_DB = 19'h01000;
    localparam logic [18:0] B_LD_IR   = 19'h00800;
    localparam logic [18:0] B_LD_AC   = 19'h00400;
    localparam logic [18:0] B_LD_PC   = 19'h00200;
    localparam logic [18:0] B_INC_PC  = 19'h00100;
    localparam logic [18:0] B_CLR_PC  = 19'h00080;
    localparam logic [18:0] B_PASS    = 19'h00040;
    localparam logic [18:0] B_ADD     = 19'h00020;
    localparam logic [18:0] B_SUB     = 19'h00010;
    localparam logic [18:0] B_ALU_DB  = 19'h00008;
    localparam logic [18:0] B_IDLE    = 19'h00004;
    localparam logic [18:0] B_HALTED  = 19'h00002;
    localparam logic [18:0] B_FAULT   = 19'h00001;

    localparam logic [18:0] W_NONE    = 19'h0;
    localparam logic [18:0] W_FWAIT   = B_MEM_REQ | B_PC_ADR | B_RD_MEM | B_DATA_DB;
    localparam logic [18:0] W_FRDY    = W_FWAIT | B_LD_IR | B_INC_PC;
    localparam logic [18:0] W_LWAIT   = B_MEM_REQ | B_IR_ADR | B_RD_MEM | B_DATA_DB;
    localparam logic [18:0] W_LRDY    = W_LWAIT | B_LD_AC;
    localparam logic [18:0] W_STA     = B_MEM_REQ | B_PASS | B_IR_ADR | B_ALU_DB | B_DB_DATA | B_WR_MEM;
    localparam logic [18:0] W_ADD     = B_ADD | B_ALU_DB | B_LD_AC;
    localparam logic [18:0] W_SUB     = B_SUB | B_ALU_DB | B_LD_AC;

    typedef struct {
        string       tag;
        logic [18:0] word;
        logic [15:0] ret;
    } exp_t;

    exp_t sb[$];

    multicycle_controller dut (
        .clk          (clk),
        .reset        (reset),
        .step         (step),
        .run          (run),
        .op_code      (op_code),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .rd_mem       (rd_mem),
        .wr_mem       (wr_mem),
        .ir_on_adr    (ir_on_adr),
        .pc_on_adr    (pc_on_adr),
        .dbus_on_data (dbus_on_data),
        .data_on_dbus (data_on_dbus),
        .ld_ir        (ld_ir),
        .ld_ac        (ld_ac),
        .ld_pc        (ld_pc),
        .inc_pc       (inc_pc),
        .clr_pc       (clr_pc),
        .pass         (pass),
        .add          (add),
        .sub          (sub),
        .alu_on_dbus  (alu_on_dbus),
        .idle         (idle),
        .halted       (halted),
        .fault        (fault),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive inputs, record expectation, compare settled
    // outputs, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic rst, input logic stp, input logic rn,
                       input logic [2:0] op, input logic z, input logic mr,
                       input logic [18:0] w);
        exp_t e;
        logic [18:0] obs;
        reset = rst; step = stp; run = rn; op_code = op; zero = z; mem_ready = mr;
        sb.push_back('{tag, w, ret});
        #1;
        e   = sb.pop_front();
        obs = {mem_req, rd_mem, wr_mem, ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus,
               ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, sub, alu_on_dbus,
               idle, halted, fault};
        $display("[TB] %s ctrl=%05h retired=%0d", e.tag, obs, retired);
        n_tests++;
        assert (obs === e.word) else begin
            n_fail++;
            $error("FAIL %s ctrl observed=%05h expected=%05h", e.tag, obs, e.word);
        end
        n_tests++;
        assert (retired === e.ret) else begin
            n_fail++;
            $error("FAIL %s retired observed=%0d expected=%0d", e.tag, retired, e.ret);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; step = 1'b0; run = 1'b0; op_code = 3'b000; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // Reset held two cycles, then single-step ADD in step mode.
        cyc("rst_a",      1, 0, 0, 3'b011, 0, 1, B_CLR_PC);
        cyc("rst_b",      1, 0, 0, 3'b011, 0, 1, B_CLR_PC);
        cyc("rst_rel",    0, 0, 0, 3'b011, 0, 1, B_CLR_PC);
        cyc("idle_hold",  0, 0, 0, 3'b011, 0, 1, B_IDLE);
        cyc("idle_step",  0, 1, 0, 3'b011, 0, 1, B_IDLE);
        cyc("add_fetch",  0, 0, 0, 3'b011, 0, 1, W_FRDY);
        cyc("add_dec",    0, 0, 0, 3'b011, 0, 1, W_NONE);
        cyc("add_exec",   0, 0, 0, 3'b011, 0, 1, W_ADD);
        ret++;
        cyc("add_idle",   0, 0, 0, 3'b000, 0, 0, B_IDLE);
        // Free-run LDA with 3 fetch waits and 2 exec waits.
        cyc("lda_idle",   0, 0, 1, 3'b000, 0, 0, B_IDLE);
        for (int i = 0; i < 3; i++) cyc("lda_fwait", 0, 0, 1, 3'b000, 0, 0, W_FWAIT);
        cyc("lda_frdy",   0, 0, 1, 3'b000, 0, 1, W_FRDY);
        cyc("lda_dec",    0, 0, 1, 3'b000, 0, 1, W_NONE);
        for (int i = 0; i < 2; i++) cyc("lda_ewait", 0, 0, 1, 3'b000, 0, 0, W_LWAIT);
        cyc("lda_erdy",   0, 0, 1, 3'b000, 0, 1, W_LRDY);
        ret++;
        // JZ not taken then taken.
        cyc("jz0_fetch",  0, 0, 1, 3'b101, 0, 1, W_FRDY);
        cyc("jz0_dec",    0, 0, 1, 3'b101, 0, 1, W_NONE);
        cyc("jz0_exec",   0, 0, 1, 3'b101, 0, 1, W_NONE);
        ret++;
        cyc("jz1_fetch",  0, 0, 1, 3'b101, 1, 1, W_FRDY);
        cyc("jz1_dec",    0, 0, 1, 3'b101, 1, 1, W_NONE);
        cyc("jz1_exec",   0, 0, 1, 3'b101, 1, 1, B_LD_PC);
        ret++;
        // JMP, SUB, NOP, then STA with one write wait.
        cyc("jmp_fetch",  0, 0, 1, 3'b010, 0, 1, W_FRDY);
        cyc("jmp_dec",    0, 0, 1, 3'b010, 0, 1, W_NONE);
        cyc("jmp_exec",   0, 0, 1, 3'b010, 0, 1, B_LD_PC);
        ret++;
        cyc("sub_fetch",  0, 0, 1, 3'b100, 0, 1, W_FRDY);
        cyc("sub_dec",    0, 0, 1, 3'b100, 0, 1, W_NONE);
        cyc("sub_exec",   0, 0, 1, 3'b100, 0, 1, W_SUB);
        ret++;
        cyc("nop_fetch",  0, 0, 1, 3'b110, 0, 1, W_FRDY);
        cyc("nop_dec",    0, 0, 1, 3'b110, 0, 1, W_NONE);
        cyc("nop_exec",   0, 0, 1, 3'b110, 0, 1, W_NONE);
        ret++;
        cyc("sta_fetch",  0, 0, 1, 3'b001, 0, 1, W_FRDY);
        cyc("sta_dec",    0, 0, 1, 3'b001, 0, 1, W_NONE);
        cyc("sta_wait",   0, 0, 1, 3'b001, 0, 0, W_STA);
        cyc("sta_rdy",    0, 0, 1, 3'b001, 0, 1, W_STA);
        ret++;
`ifdef CTRL_TIMEOUT_EN
        // Fetch stall: 16 FETCH cycles then FAULT, sticky until reset.
        for (int i = 0; i < 16; i++) cyc("to_wait", 0, 0, 1, 3'b011, 0, 0, W_FWAIT);
        for (int i = 0; i < 3; i++) cyc("to_fault", 0, 1, 1, 3'b011, 0, 1, B_FAULT);
        cyc("to_rst",     1, 0, 1, 3'b011, 0, 1, B_FAULT);
        ret = '0;
        cyc("to_rstst",   0, 0, 1, 3'b011, 0, 1, B_CLR_PC);
        cyc("to_idle",    0, 0, 1, 3'b011, 0, 1, B_IDLE);
`else
        // Without the watchdog a fetch stall waits indefinitely.
        for (int i = 0; i < 20; i++) cyc("long_wait", 0, 0, 1, 3'b011, 0, 0, W_FWAIT);
`endif
        // HLT: halted and sticky against run/step until reset.
        cyc("hlt_fetch",  0, 0, 1, 3'b111, 0, 1, W_FRDY);
        cyc("hlt_dec",    0, 0, 1, 3'b111, 0, 1, W_NONE);
        cyc("hlt_exec",   0, 0, 1, 3'b111, 0, 1, W_NONE);
        ret++;
        for (int i = 0; i < 10; i++) cyc("halt_hold", 0, 1, logic'(i % 2), 3'b011, 0, 1, B_HALTED);
        cyc("halt_rst",   1, 0, 1, 3'b011, 0, 1, B_HALTED);
        ret = '0;
        cyc("halt_rstst", 0, 0, 1, 3'b011, 0, 1, B_CLR_PC);
        cyc("re_idle",    0, 0, 1, 3'b011, 0, 1, B_IDLE);
        cyc("re_fetch",   0, 0, 1, 3'b011, 0, 1, W_FRDY);
        cyc("re_dec",     0, 0, 1, 3'b011, 0, 1, W_NONE);
        cyc("re_exec",    0, 0, 1, 3'b011, 0, 1, W_ADD);
        ret++;
        // Reset asserted in the middle of an STA write wait.
        cyc("sr_fetch",   0, 0, 1, 3'b001, 0, 1, W_FRDY);
        cyc("sr_dec",     0, 0, 1, 3'b001, 0, 1, W_NONE);
        cyc("sr_wait",    0, 0, 1, 3'b001, 0, 0, W_STA);
        cyc("sr_wait_rst",1, 0, 1, 3'b001, 0, 0, W_STA);
        ret = '0;
        cyc("sr_after",   0, 0, 1, 3'b001, 0, 0, B_CLR_PC);
        cyc("sr_idle",    0, 0, 0, 3'b001, 0, 0, B_IDLE);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter CNT_W, 16, width of retired-instruction counter.
REQ-002 Parameter TO_W, 4, width of memory-wait timeout counter.
REQ-003 Parameter TIMEOUT, 15, max wait cycles before fault; SHALL be at most 2**TO_W-1.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 step  in  1  single-step request, sampled in IDLE.
REQ-007 run  in  1  1 = free-run, 0 = step mode.
REQ-008 op_code  in  3  opcode from IR.
REQ-009 zero  in  1  accumulator-zero flag.
REQ-010 mem_ready  in  1  memory completes current access this cycle.
REQ-011 mem_req, rd_mem, wr_mem, ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus  out  1 each  memory/bus controls.
REQ-012 ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, sub, alu_on_dbus  out  1 each  datapath controls.
REQ-013 idle, halted, fault  out  1 each  status.
REQ-014 retired  out  CNT_W  count of completed instructions.

Function
REQ-015 States: RESET, IDLE, FETCH, DECODE, EXEC, HALT, FAULT; all outputs SHALL default to 0 except as listed.
REQ-016 RESET: clr_pc=1; next IDLE when reset=0.
REQ-017 IDLE: idle=1; next FETCH if run=1 or step=1, else IDLE.
REQ-018 FETCH: mem_req, pc_on_adr, rd_mem, data_on_dbus held; ld_ir=inc_pc=mem_ready; next DECODE when mem_ready=1, else FETCH.
REQ-019 DECODE: no outputs; next EXEC after exactly 1 cycle.
REQ-020 EXEC 000 LDA: mem_req, ir_on_adr, rd_mem, data_on_dbus held; ld_ac=mem_ready; completes on mem_ready.
REQ-021 EXEC 001 STA: mem_req, pass, ir_on_adr, alu_on_dbus, dbus_on_data, wr_mem held; completes on mem_ready.
REQ-022 EXEC 010 JMP: ld_pc=1; 1 cycle.
REQ-023 EXEC 011 ADD: add, alu_on_dbus, ld_ac; 1 cycle. 100 SUB: same with sub instead of add.
REQ-024 EXEC 101 JZ: ld_pc=zero; 1 cycle. 110 NOP: no outputs; 1 cycle.
REQ-025 EXEC 111 HLT: 1 cycle; next HALT.
REQ-026 On EXEC completion (non-HLT): next FETCH if run=1, else IDLE.
REQ-027 HALT: halted=1; exits only via reset.
REQ-028 Memory control outputs SHALL remain stable every cycle of a wait; mem_ready outside FETCH/memory EXEC SHALL be ignored.
REQ-029 retired SHALL increment by 1 in the cycle EXEC completes, HLT included; wraps from all-ones to 0.
REQ-030 Fetch cycle latency = 1 + wait cycles; non-memory instruction = FETCH+DECODE+EXEC = 3 cycles at zero wait.

Reset
REQ-031 reset=1 in any state, including mid-wait, SHALL force RESET on next edge; retired and timeout counter SHALL clear to 0.
REQ-032 Whilst in RESET: clr_pc=1, every other output 0, retired=0, fault=0.

Configuration
REQ-033 Macro CTRL_TIMEOUT_EN defined: wait counter increments each cycle with mem_req=1 and mem_ready=0, clears on any state change; when it equals TIMEOUT with mem_ready=0, next state FAULT; FAULT drives fault=1, all else 0, exits only via reset.
REQ-034 CTRL_TIMEOUT_EN undefined: no counter, no FAULT transition, waits indefinitely; fault tied 0.

Structure
REQ-035 Package ctrl_pkg SHALL hold the state encoding and the eight opcode constants.
REQ-036 Watchdog counter SHALL be sub-module ctrl_mem_watchdog, instantiated only under CTRL_TIMEOUT_EN.

Verification
REQ-037 reset 2 cycles, run=0, step pulse, op=011, mem_ready=1 -> FETCH, DECODE, EXEC with add=ld_ac=1 for one cycle, back to IDLE, retired=1.
REQ-038 run=1, LDA with mem_ready low 3 cycles in FETCH and 2 in EXEC -> controls stable throughout, ld_ir/ld_ac only on ready cycle, retired=1 after 8 cycles.
REQ-039 JZ with zero=0 then zero=1 -> ld_pc 0 then 1.
REQ-040 HLT under run=1 -> halted=1, step and run ignored for 10 cycles; reset returns to RESET.
REQ-041 CTRL_TIMEOUT_EN, TIMEOUT=15, mem_ready held 0 in FETCH -> fault=1 after 16 cycles in FETCH; unsticks only on reset.
REQ-042 reset asserted mid-STA wait -> wr_mem=0 next cycle, clr_pc=1, retired=0.
